// File: rtl/dmem_ctrl.sv
// Load/store front end for a 256x16 simple-dual-port data RAM: one request at a time,
// byte-to-word address translation and read latency handling. Byte accesses need DMEM_RMW_BYTE_EN.
module dmem_ctrl #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_byte,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_cea,
  output logic [AW-2:0] mem_ada,
  output logic [DW-1:0] mem_din,
  output logic          mem_ceb,
  output logic [AW-2:0] mem_adb,
  input  logic [DW-1:0] mem_dout
);

  localparam int WAW = AW - 1;

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; rsp_valid is a single-cycle completion pulse with no back-pressure.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD        = 3'd1,
    S_RD_DATA   = 3'd2,
    S_WR        = 3'd3,
    S_ERR       = 3'd4
`ifdef DMEM_RMW_BYTE_EN
    , S_RMW_RD    = 3'd5,
    S_RMW_MERGE = 3'd6
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [WAW-1:0] word_addr_q, word_addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
`ifdef DMEM_RMW_BYTE_EN
  logic           byte_q, byte_d;
  logic           lsb_q, lsb_d;
  logic [DW-1:0]  merged_q, merged_d;
`endif

  logic idle_rdy;
  assign idle_rdy = (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
`ifdef DMEM_RMW_BYTE_EN
    byte_d      = byte_q;
    lsb_d       = lsb_q;
    merged_d    = merged_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && idle_rdy) begin
          word_addr_d = req_addr[AW-1:1];
          wdata_d     = req_wdata;
`ifdef DMEM_RMW_BYTE_EN
          byte_d      = req_byte;
          lsb_d       = req_addr[0];
          if (!req_byte && req_addr[0]) state_d = S_ERR;
          else if (!req_we)             state_d = S_RD;
          else if (req_byte)            state_d = S_RMW_RD;
          else                          state_d = S_WR;
`else
          // Without read-modify-write support every byte access is rejected.
          if (req_byte || req_addr[0]) state_d = S_ERR;
          else if (!req_we)            state_d = S_RD;
          else                         state_d = S_WR;
`endif
        end
      end
      S_RD:      state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_IDLE;
`ifdef DMEM_RMW_BYTE_EN
      S_RMW_RD:  state_d = S_RMW_MERGE;
      S_RMW_MERGE: begin
        merged_d = lsb_q ? {wdata_q[7:0], mem_dout[7:0]}
                         : {mem_dout[DW-1:8], wdata_q[7:0]};
        state_d  = S_WR;
      end
`endif
      S_WR:      state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_addr_q <= '0;
      wdata_q     <= '0;
`ifdef DMEM_RMW_BYTE_EN
      byte_q      <= 1'b0;
      lsb_q       <= 1'b0;
      merged_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
`ifdef DMEM_RMW_BYTE_EN
      byte_q      <= byte_d;
      lsb_q       <= lsb_d;
      merged_q    <= merged_d;
`endif
    end
  end

  // Outputs depend only on state and captured registers (plus RAM read data),
  // so reset clears them at once and no req_* input reaches the RAM ports.
  always_comb begin
    req_ready = idle_rdy && !rst;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_cea   = 1'b0;
    mem_ada   = '0;
    mem_din   = '0;
    mem_ceb   = 1'b0;
    mem_adb   = '0;
    case (state_q)
      S_RD: begin
        mem_ceb = 1'b1;
        mem_adb = word_addr_q;
      end
      S_RD_DATA: begin
        rsp_valid = 1'b1;
        rsp_rdata = mem_dout;
`ifdef DMEM_RMW_BYTE_EN
        if (byte_q)
          rsp_rdata = {{(DW-8){1'b0}}, (lsb_q ? mem_dout[DW-1:8] : mem_dout[7:0])};
`endif
      end
`ifdef DMEM_RMW_BYTE_EN
      S_RMW_RD: begin
        mem_ceb = 1'b1;
        mem_adb = word_addr_q;
      end
`endif
      S_WR: begin
        mem_cea   = 1'b1;
        mem_ada   = word_addr_q;
        mem_din   = wdata_q;
`ifdef DMEM_RMW_BYTE_EN
        if (byte_q) mem_din = merged_q;
`endif
        rsp_valid = 1'b1;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural 256x16 RAM (one-cycle read latency).
// Byte-access expectations follow whether DMEM_RMW_BYTE_EN is defined.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_byte;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        mem_cea, mem_ceb;
  logic [7:0]  mem_ada, mem_adb;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  logic [15:0] ram [256];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] r_data, r_din;
  logic        r_err, r_cea, r_ceb;
  logic [7:0]  r_ada, r_adb;
  logic [15:0] r_lat;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_cea(mem_cea), .mem_ada(mem_ada), .mem_din(mem_din),
    .mem_ceb(mem_ceb), .mem_adb(mem_adb), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cea) ram[mem_ada] <= mem_din;
    if (mem_ceb) mem_dout <= ram[mem_adb];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issues one request, then records the response and any RAM activity until rsp_valid.
  task automatic do_req(input string tag, input logic we, input logic byt,
                        input logic [8:0] addr, input logic [15:0] wd);
    logic got;
    @(negedge clk);
    chk({tag, "_ready"}, 16'(req_ready), 16'h1);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
    got = 1'b0;
    r_cea = 1'b0; r_ceb = 1'b0; r_ada = '0; r_adb = '0; r_din = '0;
    r_data = '0; r_err = 1'b0; r_lat = '0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (mem_cea) begin r_cea = 1'b1; r_ada = mem_ada; r_din = mem_din; end
      if (mem_ceb) begin r_ceb = 1'b1; r_adb = mem_adb; end
      if (rsp_valid) begin
        got = 1'b1; r_lat = 16'(i); r_data = rsp_rdata; r_err = rsp_err;
      end
    end
    if (!got) chk({tag, "_timeout"}, 16'h0, 16'h1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    mem_dout = 16'h0000;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rst_cea", 16'(mem_cea), 16'h0);
    chk("rst_ceb", 16'(mem_ceb), 16'h0);
    chk("rst_rdata", rsp_rdata, 16'h0);
    rst = 1'b0;

    // Word store then word load.
    do_req("st_beef", 1'b1, 1'b0, 9'h010, 16'hBEEF);
    chk("st_beef_lat", r_lat, 16'h1);
    chk("st_beef_cea", 16'(r_cea), 16'h1);
    chk("st_beef_ada", 16'(r_ada), 16'h08);
    chk("st_beef_din", r_din, 16'hBEEF);
    chk("st_beef_rdata", r_data, 16'h0);
    chk("st_beef_err", 16'(r_err), 16'h0);
    do_req("ld_beef", 1'b0, 1'b0, 9'h010, 16'h0);
    chk("ld_beef_lat", r_lat, 16'h2);
    chk("ld_beef_adb", 16'(r_adb), 16'h08);
    chk("ld_beef_cea", 16'(r_cea), 16'h0);
    chk("ld_beef_data", r_data, 16'hBEEF);
    chk("ld_beef_err", 16'(r_err), 16'h0);

    // Byte store into an existing word.
    do_req("st_1234", 1'b1, 1'b0, 9'h020, 16'h1234);
    do_req("stb_ab", 1'b1, 1'b1, 9'h021, 16'h00AB);
`ifdef DMEM_RMW_BYTE_EN
    chk("stb_ab_lat", r_lat, 16'h3);
    chk("stb_ab_ada", 16'(r_ada), 16'h10);
    chk("stb_ab_din", r_din, 16'hAB34);
    chk("stb_ab_err", 16'(r_err), 16'h0);
    do_req("ld_ab34", 1'b0, 1'b0, 9'h020, 16'h0);
    chk("ld_ab34_data", r_data, 16'hAB34);
`else
    chk("stb_ab_lat", r_lat, 16'h1);
    chk("stb_ab_err", 16'(r_err), 16'h1);
    chk("stb_ab_cea", 16'(r_cea), 16'h0);
    chk("stb_ab_ceb", 16'(r_ceb), 16'h0);
    do_req("ld_1234", 1'b0, 1'b0, 9'h020, 16'h0);
    chk("ld_1234_data", r_data, 16'h1234);
`endif

    // Byte loads, both halves.
    do_req("st_5a6b", 1'b1, 1'b0, 9'h030, 16'h5A6B);
    do_req("ldb_hi", 1'b0, 1'b1, 9'h031, 16'h0);
`ifdef DMEM_RMW_BYTE_EN
    chk("ldb_hi_lat", r_lat, 16'h2);
    chk("ldb_hi_data", r_data, 16'h005A);
    do_req("ldb_lo", 1'b0, 1'b1, 9'h030, 16'h0);
    chk("ldb_lo_data", r_data, 16'h006B);
`else
    chk("ldb_hi_err", 16'(r_err), 16'h1);
    chk("ldb_hi_data", r_data, 16'h0);
    chk("ldb_hi_ceb", 16'(r_ceb), 16'h0);
`endif

    // Misaligned word accesses.
    do_req("ld_mis", 1'b0, 1'b0, 9'h003, 16'h0);
    chk("ld_mis_lat", r_lat, 16'h1);
    chk("ld_mis_err", 16'(r_err), 16'h1);
    chk("ld_mis_data", r_data, 16'h0);
    chk("ld_mis_cea", 16'(r_cea), 16'h0);
    chk("ld_mis_ceb", 16'(r_ceb), 16'h0);
    do_req("st_mis", 1'b1, 1'b0, 9'h005, 16'hFFFF);
    chk("st_mis_err", 16'(r_err), 16'h1);
    chk("st_mis_cea", 16'(r_cea), 16'h0);

    // Reset during the write cycle of a word store must block the write.
    do_req("st_1111", 1'b1, 1'b0, 9'h040, 16'h1111);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 9'h040; req_wdata = 16'h9999;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    chk("wr_before_rst_cea", 16'(mem_cea), 16'h1);
    rst = 1'b1;
    #1;
    chk("wr_rst_cea", 16'(mem_cea), 16'h0);
    chk("wr_rst_rsp", 16'(rsp_valid), 16'h0);
    chk("wr_rst_ready", 16'(req_ready), 16'h0);
    repeat (2) @(negedge clk);
    chk("wr_rst_hold_cea", 16'(mem_cea), 16'h0);
    rst = 1'b0;
    do_req("ld_after_rst", 1'b0, 1'b0, 9'h040, 16'h0);
    chk("ld_after_rst_data", r_data, 16'h1111);

`ifdef DMEM_RMW_BYTE_EN
    // Reset during the merge cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 9'h041; req_wdata = 16'h0022;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmw_rst_cea", 16'(mem_cea), 16'h0);
    chk("rmw_rst_ceb", 16'(mem_ceb), 16'h0);
    chk("rmw_rst_rsp", 16'(rsp_valid), 16'h0);
    chk("rmw_rst_ready", 16'(req_ready), 16'h0);
    repeat (2) @(negedge clk);
    chk("rmw_rst_hold_cea", 16'(mem_cea), 16'h0);
    rst = 1'b0;
    do_req("ld_after_rmw_rst", 1'b0, 1'b0, 9'h040, 16'h0);
    chk("ld_after_rmw_rst_data", r_data, 16'h1111);
`endif

    // Top of the address space.
    do_req("st_7788", 1'b1, 1'b0, 9'h1FE, 16'h7788);
    chk("st_7788_ada", 16'(r_ada), 16'hFF);
    do_req("stb_cd", 1'b1, 1'b1, 9'h1FF, 16'h00CD);
`ifdef DMEM_RMW_BYTE_EN
    chk("stb_cd_ada", 16'(r_ada), 16'hFF);
    chk("stb_cd_din", r_din, 16'hCD88);
    chk("stb_cd_err", 16'(r_err), 16'h0);
    do_req("ld_top", 1'b0, 1'b0, 9'h1FE, 16'h0);
    chk("ld_top_data", r_data, 16'hCD88);
`else
    chk("stb_cd_err", 16'(r_err), 16'h1);
    chk("stb_cd_cea", 16'(r_cea), 16'h0);
    do_req("ld_top", 1'b0, 1'b0, 9'h1FE, 16'h0);
    chk("ld_top_data", r_data, 16'h7788);
`endif
    chk("ld_top_adb", 16'(r_adb), 16'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
